a2d_spi_responder: RTL and testbench

//  Synthesizable SPI responder for the A2D path: answers the A2D SPI master exactly as the ADC128S does.
//  The channel address received in frame N selects the 12-bit result returned in frame N+1.

---
 rtl/a2d_pkg.sv | 34 +++
 rtl/spi_edge_sync.sv | 32 +++
 rtl/a2d_spi_responder.sv | 158 +++++++++++++++
 tb/tb_a2d_spi_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D SPI responder (ADC128S-compatible frame format).
package a2d_pkg;

  localparam int NUM_CH       = 8;
  localparam int DATA_W       = 12;
  localparam int FRAME_BITS   = 16;
  localparam int SYNC_STAGES  = 2;
  localparam int ADDR_IDX_MSB = 13;
  localparam int ADDR_IDX_LSB = 11;
  localparam int ADDR_W       = ADDR_IDX_MSB - ADDR_IDX_LSB + 1;
  localparam int CNT_W        = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    XFER = 2'd2
  } a2d_rsp_state_t;

  typedef struct packed {
    a2d_rsp_state_t   state;
    logic             ss_n;
    logic             sclk;
    logic             mosi;
    logic [CNT_W-1:0] bit_cnt;
  } a2d_rsp_dbg_t;

  // Result word as it goes on the wire: four leading zeros, then the sample MSB first.
  function automatic logic [FRAME_BITS-1:0] pad_result(input logic [DATA_W-1:0] d);
    return {{(FRAME_BITS - DATA_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pin, plus single-clk rise/fall pulses
// derived from the synchronized level (one extra clk of latency).
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/a2d_spi_responder.sv
// SPI responder emulating an ADC128S: the address received in one frame selects the
// 12-bit channel sample shifted out on MISO during the following frame.
module a2d_spi_responder #(
  parameter int NUM_CH      = a2d_pkg::NUM_CH,
  parameter int SYNC_STAGES = a2d_pkg::SYNC_STAGES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 SS_n,
  input  logic                                 SCLK,
  input  logic                                 MOSI,
  output logic                                 MISO,
  input  logic [NUM_CH*a2d_pkg::DATA_W-1:0]    chnl_data,
  output logic                                 frm_done,
  output logic                                 frm_err,
  output logic [a2d_pkg::ADDR_W-1:0]           last_chnnl,
  output a2d_pkg::a2d_rsp_dbg_t                dbg_o
);

  import a2d_pkg::*;

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  // SS_n syncs reset to "selected" so a frame already running at reset cannot
  // produce a false fall; ARM then waits for the master to deselect.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (SS_n),
    .level_o (ss_s),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (SCLK),
    .level_o (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  a2d_rsp_state_t          state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  // Bit 15 of the received word would never be read, so only 15 bits are kept.
  logic [FRAME_BITS-2:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]       ch_sel_q, ch_sel_d;
  logic [ADDR_W-1:0]       last_q, last_d;
  logic                    miso_q, miso_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       sel_data;

  // Unpopulated addresses fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel_q == ADDR_W'(c)) sel_data = chnl_data[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ch_sel_d  = ch_sel_q;
    last_d    = last_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ARM: begin
        if (ss_s) state_d = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          tx_d      = pad_result(sel_data);
          bit_cnt_d = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        // Deselect takes priority; an SCLK edge seen on the same clk is dropped.
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == LAST_BIT) begin
            ch_sel_d = rx_q[ADDR_IDX_MSB:ADDR_IDX_LSB];
            last_d   = rx_q[ADDR_IDX_MSB:ADDR_IDX_LSB];
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sclk_rise && (bit_cnt_q != LAST_BIT)) begin
            rx_d      = {rx_q[FRAME_BITS-3:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) begin
            if ((bit_cnt_q != '0) && (bit_cnt_q != LAST_BIT)) tx_d = tx_q << 1;
            else if (bit_cnt_q == LAST_BIT)                   tx_d = '0;
          end
        end
      end
      default: state_d = ARM;
    endcase
    miso_d = (state_d == XFER) ? tx_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARM;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ch_sel_q  <= '0;
      last_q    <= '0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ch_sel_q  <= ch_sel_d;
      last_q    <= last_d;
      miso_q    <= miso_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign MISO       = miso_q;
  assign frm_done   = done_q;
  assign frm_err    = err_q;
  assign last_chnnl = last_q;

  always_comb begin
    dbg_o         = '0;
    dbg_o.state   = state_q;
    dbg_o.ss_n    = ss_s;
    dbg_o.sclk    = sclk_s;
    dbg_o.mosi    = mosi_s;
    dbg_o.bit_cnt = bit_cnt_q;
  end

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Bench for a2d_spi_responder: SPI master model driving frames, table of hand-derived
// frame results, corner-case sequences and a randomized scoreboard run.
module tb_a2d_spi_responder;
  import a2d_pkg::*;

  localparam int HALF   = 5;
  localparam int N_RAND = 150;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     ss_n = 1'b1;
  logic                     sclk = 1'b1;
  logic                     mosi = 1'b0;
  logic                     miso;
  logic [NUM_CH*DATA_W-1:0] chnl_data;
  logic                     frm_done;
  logic                     frm_err;
  logic [ADDR_W-1:0]        last_chnnl;
  a2d_rsp_dbg_t             dbg;

  always #5 clk = ~clk;

  a2d_spi_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (ss_n),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .chnl_data  (chnl_data),
    .frm_done   (frm_done),
    .frm_err    (frm_err),
    .last_chnnl (last_chnnl),
    .dbg_o      (dbg)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (frm_done) done_cnt++;
    if (frm_err)  err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ch_val(input int c);
    return chnl_data[c*DATA_W +: DATA_W];
  endfunction

  task automatic set_ch(input int c, input logic [DATA_W-1:0] v);
    chnl_data[c*DATA_W +: DATA_W] = v;
  endtask

  // One master frame (SCLK idles high, MOSI changes on fall, MISO sampled just before rise).
  // Bits past 16 drive MOSI=1. Optionally scrambles chnl_data mid-frame and pulses rst_n.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int gap,
                           input bit scramble, input int rst_bit, output logic [31:0] word);
    word = '0;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      sclk = 1'b0;
      mosi = (b < 16) ? cmd[15-b] : 1'b1;
      repeat (HALF) @(negedge clk);
      word = {word[30:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (scramble && b == 4) begin
        for (int c = 0; c < NUM_CH; c++) set_ch(c, DATA_W'($urandom_range(0, 4095)));
      end
      if (b == rst_bit) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    ss_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0]       cmd;
    int                nbits;
    logic [31:0]       exp_word;
    logic [ADDR_W-1:0] exp_last;
    int                exp_done;
    int                exp_err;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] w;
  logic [31:0] exp_w;
  int          d0, e0, gap;
  logic [15:0] cmd;
  logic [2:0]  model_sel;
  bit          scr;

  initial begin
    // Channel c holds 0x100*c+c; the first two frames use 0xA5C on channel 3.
    tbl[0]  = '{16'h0800, 16, 32'h0000_0000, 3'd1, 1, 0};
    tbl[1]  = '{16'h1000, 16, 32'h0000_0101, 3'd2, 1, 0};
    tbl[2]  = '{16'h1800, 16, 32'h0000_0202, 3'd3, 1, 0};
    tbl[3]  = '{16'h2000, 16, 32'h0000_0303, 3'd4, 1, 0};
    tbl[4]  = '{16'h2800, 16, 32'h0000_0404, 3'd5, 1, 0};
    tbl[5]  = '{16'h3000, 16, 32'h0000_0505, 3'd6, 1, 0};
    tbl[6]  = '{16'h3800, 16, 32'h0000_0606, 3'd7, 1, 0};
    tbl[7]  = '{16'h0800,  9, 32'h0000_000E, 3'd7, 0, 1};
    tbl[8]  = '{16'h0000, 16, 32'h0000_0707, 3'd0, 1, 0};
    tbl[9]  = '{16'h3800, 16, 32'h0000_0000, 3'd7, 1, 0};
    tbl[10] = '{16'h1000, 18, 32'h0000_1C1C, 3'd2, 1, 0};
    tbl[11] = '{16'h0000, 16, 32'h0000_0202, 3'd0, 1, 0};

    for (int c = 0; c < NUM_CH; c++) set_ch(c, DATA_W'(12'h101 * c));
    set_ch(3, 12'hA5C);

    // Reset with SS_n high
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg.state), 32'(ARM));
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_last", 32'(last_chnnl), 32'h0);
    check("rst_done", 32'(frm_done), 32'h0);
    check("rst_err", 32'(frm_err), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arm_to_idle", 32'(dbg.state), 32'(IDLE));

    // Frame 1 returns ch0, frame 2 returns ch3 addressed in frame 1
    d0 = done_cnt;
    spi_frame(16'h1800, 16, 8, 1'b0, -1, w);
    check("f1_miso", w, 32'h0000_0000);
    check("f1_last", 32'(last_chnnl), 32'd3);
    check("f1_done", 32'(done_cnt - d0), 32'd1);
    spi_frame(16'h0000, 16, 8, 1'b0, -1, w);
    check("f2_miso", w, 32'h0000_0A5C);
    check("f2_last", 32'(last_chnnl), 32'd0);

    set_ch(3, 12'h303);
    for (int i = 0; i < 12; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      spi_frame(tbl[i].cmd, tbl[i].nbits, 8, 1'b0, -1, w);
      check($sformatf("tbl%0d_miso", i), w, tbl[i].exp_word);
      check($sformatf("tbl%0d_last", i), 32'(last_chnnl), 32'(tbl[i].exp_last));
      check($sformatf("tbl%0d_done", i), 32'(done_cnt - d0), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_err", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
    end

    // Randomized frames, back-to-back gaps, chnl_data changing mid-frame
    model_sel = 3'd0;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < N_RAND; i++) begin
      cmd = 16'($urandom_range(0, 65535));
      gap = $urandom_range(1, 6);
      scr = 1'($urandom_range(0, 1));
      exp_q.push_back({20'h0, ch_val(int'(model_sel))});
      spi_frame(cmd, 16, gap, scr, -1, w);
      exp_w = exp_q.pop_front();
      check($sformatf("rand%0d_miso", i), w, exp_w);
      model_sel = cmd[ADDR_IDX_MSB:ADDR_IDX_LSB];
    end
    repeat (8) @(negedge clk);
    check("rand_done_total", 32'(done_cnt - d0), 32'(N_RAND));
    check("rand_err_total", 32'(err_cnt - e0), 32'h0);
    check("rand_last", 32'(last_chnnl), 32'(model_sel));

    // Reset mid-frame: rest of frame ignored, next frame returns ch0
    set_ch(5, 12'hFFF);
    set_ch(0, 12'h5A1);
    spi_frame(16'h2800, 16, 8, 1'b0, -1, w);
    check("pre_rst_last", 32'(last_chnnl), 32'd5);
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(16'h1800, 16, 8, 1'b0, 6, w);
    check("midrst_miso_tail", {23'h0, w[8:0]}, 32'h0);
    check("midrst_last", 32'(last_chnnl), 32'd0);
    check("midrst_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_state", 32'(dbg.state), 32'(IDLE));
    spi_frame(16'h0000, 16, 8, 1'b0, -1, w);
    check("post_rst_miso", w, 32'h0000_05A1);
    check("post_rst_last", 32'(last_chnnl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
